// File: rtl/apb_rr_master_arb_if.sv
// rtl/apb_rr_master_arb_if.sv - requester and APB signal bundle for the round-robin APB master arbiter
// The master modport is the arbiter's view; the slave modport is the view of the requesters and the APB slave.
interface apb_rr_master_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        req_write_i;
    logic [NUM_REQ*STRB_W-1:0] req_strb_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      err_o;

    logic [ADDR_W-1:0]         paddr_o;
    logic [DATA_W-1:0]         pwdata_o;
    logic                      pwrite_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [STRB_W-1:0]         pstrb_o;
    logic [DATA_W-1:0]         prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_i, req_addr_i, req_wdata_i, req_write_i, req_strb_i,
        output gnt_o, done_o, rdata_o, err_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        output req_i, req_addr_i, req_wdata_i, req_write_i, req_strb_i,
        input  gnt_o, done_o, rdata_o, err_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/apb_rr_master_arb.sv
// rtl/apb_rr_master_arb.sv - round-robin arbiter sharing one APB master port among NUM_REQ requesters
// Sequences IDLE/SETUP/ACCESS, latches the winner's payload at grant, and optionally times out stuck slaves.
module apb_rr_master_arb #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 pclk_i,
    input  logic                 preset_i,
    apb_rr_master_arb_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_W:0]   NREQ      = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   wdog;

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum;
    logic [IDX_W-1:0]     pick;
    logic                 any_req;
    logic [IDX_W-1:0]     nxt_ptr;

    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_write;
    logic [STRB_W-1:0]    sel_strb;

    // Rotate the request vector so the pointer sits at bit 0; the lowest set bit is the winner's offset.
    always_comb begin
        req_dbl = {bus.req_i, bus.req_i};
        req_rot = req_dbl[ptr +: NUM_REQ];
        any_req = |bus.req_i;
        off     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum  = {1'b0, ptr} + {1'b0, off};
        pick = (sum >= NREQ) ? IDX_W'(sum - NREQ) : sum[IDX_W-1:0];
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_strb  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                sel_addr  = bus.req_addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata_i[k*DATA_W +: DATA_W];
                sel_write = bus.req_write_i[k];
                sel_strb  = bus.req_strb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign nxt_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state         <= S_IDLE;
            ptr           <= '0;
            owner         <= '0;
            wdog          <= '0;
            bus.gnt_o     <= '0;
            bus.done_o    <= '0;
            bus.rdata_o   <= '0;
            bus.err_o     <= 1'b0;
            bus.paddr_o   <= '0;
            bus.pwdata_o  <= '0;
            bus.pwrite_o  <= 1'b0;
            bus.psel_o    <= 1'b0;
            bus.penable_o <= 1'b0;
            bus.pstrb_o   <= '0;
        end else begin
            bus.done_o <= '0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner         <= pick;
                        bus.gnt_o     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        bus.paddr_o   <= sel_addr;
                        bus.pwdata_o  <= sel_wdata;
                        bus.pwrite_o  <= sel_write;
                        bus.pstrb_o   <= sel_write ? sel_strb : '0;
                        bus.psel_o    <= 1'b1;
                        bus.penable_o <= 1'b0;
                        state         <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bus.penable_o <= 1'b1;
                    wdog          <= '0;
                    state         <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A real response and a watchdog expiry share the same teardown of the APB port.
                    if (bus.pready_i || (TIMEOUT_CYCLES != 0 && wdog == WDOG_LAST)) begin
                        bus.done_o    <= bus.gnt_o;
                        bus.gnt_o     <= '0;
                        bus.psel_o    <= 1'b0;
                        bus.penable_o <= 1'b0;
                        bus.paddr_o   <= '0;
                        bus.pwdata_o  <= '0;
                        bus.pwrite_o  <= 1'b0;
                        bus.pstrb_o   <= '0;
                        ptr           <= nxt_ptr;
                        state         <= S_IDLE;
                        if (bus.pready_i) begin
                            bus.err_o <= bus.pslverr_i;
                            if (!bus.pwrite_o) begin
                                bus.rdata_o <= bus.prdata_i;
                            end
                        end else begin
                            bus.err_o   <= 1'b1;
                            bus.rdata_o <= '0;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/apb_rr_master_arb.md
Name: apb_rr_master_arb

Overview:
- Shares the single APB master port feeding the APB-to-MIG DDR bridge among NUM_REQ on-chip requesters, using round-robin arbitration.
- Sequences the APB IDLE/SETUP/ACCESS phases and latches each granted request's payload.
- Returns read data and error status to the owning requester.
- Optional watchdog terminates transfers when the slave never asserts pready.

Parameters:
- NUM_REQ, 3, number of requesters (>=2).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width; STRB_W = DATA_W/8 (derived, not overridable).
- TIMEOUT_CYCLES, 256, max ACCESS cycles with pready low before forced termination; 0 disables the watchdog.

Ports:
- pclk_i  in  1  clock.
- preset_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester transfer request.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data.
- req_write_i  in  NUM_REQ  1=write, 0=read.
- req_strb_i  in  NUM_REQ*STRB_W  packed byte strobes.
- gnt_o  out  NUM_REQ  one-hot current owner.
- done_o  out  NUM_REQ  one-cycle completion pulse.
- rdata_o  out  DATA_W  read data of the last completed read (shared by all requesters).
- err_o  out  1  error of the last completion, valid when any done_o bit is high.
- paddr_o  out  ADDR_W  APB address.
- pwdata_o  out  DATA_W  APB write data.
- pwrite_o  out  1  APB write enable.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pstrb_o  out  STRB_W  APB strobes.
- prdata_i  in  DATA_W  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset (sampled on pclk_i rising edge):
  - All outputs 0; state IDLE.
  - Round-robin pointer = 0; watchdog counter = 0.
  - Reset mid-transfer aborts immediately: psel_o and penable_o drop the next cycle and no done_o pulse is issued.
- FSM states are IDLE, SETUP and ACCESS. All outputs are registered.
- IDLE:
  - If any req_i bit is high, grant the first set bit at or above the pointer, wrapping modulo NUM_REQ.
  - On the grant, latch that requester's addr, wdata, write and strb into the paddr/pwdata/pwrite/pstrb registers.
  - Drive pstrb_o = 0 when req_write_i = 0.
  - Set psel_o = 1, penable_o = 0, gnt_o = onehot(winner); go to SETUP.
  - If no req_i bit is high, stay in IDLE with all APB outputs held at 0.
- SETUP: next cycle penable_o = 1; clear the watchdog counter; go to ACCESS.
- ACCESS with pready_i = 1:
  - done_o[winner] = 1 for one cycle.
  - err_o = pslverr_i.
  - rdata_o = prdata_i for reads; for writes rdata_o holds its previous value.
  - psel_o, penable_o and gnt_o clear; pointer = (winner+1) mod NUM_REQ; go to IDLE.
- ACCESS with pready_i = 0:
  - Increment the watchdog counter; APB outputs are held stable.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with pready_i still low, terminate the transfer.
  - On termination: done_o[winner] = 1, err_o = 1, rdata_o = 0; psel_o and penable_o drop; pointer advances; go to IDLE.
- Timing:
  - Minimum transfer is 3 cycles (IDLE-grant, SETUP, ACCESS).
  - Back-to-back transfers are separated by at least one IDLE cycle with psel_o = 0.
  - Grant-to-done latency is 2 + wait-state cycles.
- Requester contract:
  - Hold req_i high until done_o.
  - The payload is sampled only at the grant; changes after the grant are ignored.
  - Dropping req_i after the grant does not cancel the transfer, which completes normally.
  - Keeping req_i high in the cycle after done_o re-enters arbitration; the requester now has lowest priority.
- Simultaneous requests: strict round-robin, so no requester waits more than NUM_REQ-1 transfers.
- Boundary cases:
  - Pointer wrap: NUM_REQ-1 → 0.
  - pslverr_i is ignored unless pready_i = 1.
  - With TIMEOUT_CYCLES = 0 the FSM waits indefinitely.

Test Plan:
1. Single write: req_i=3'b001, addr 0x100, wdata 0xDEADBEEF, strb 4'hF, pready high in the first ACCESS cycle → psel_o high for 2 cycles, penable_o for 1, done_o=3'b001 at cycle 3, err_o=0.
2. Read with 2 wait states: requester 1 reads 0x200, slave returns 0xCAFEF00D → penable_o high for 3 cycles, pstrb_o=0, done_o=3'b010, rdata_o=0xCAFEF00D.
3. Contention: req_i=3'b111 held continuously, zero-wait slave → grant order 0,1,2,0, each done_o pulse 3 cycles apart, psel_o low for 1 cycle between transfers.
4. Slave error: pslverr_i=1 together with pready_i → err_o=1 with the done_o pulse; on the next transfer with pslverr_i=0, err_o=0.
5. Timeout: TIMEOUT_CYCLES=4, pready_i held low → after 4 ACCESS cycles done_o pulses, err_o=1, rdata_o=0, psel_o drops, pointer advances.
6. Reset mid-ACCESS: assert preset_i during a wait state → next cycle all outputs are 0, no done_o pulse, and the first grant after reset goes to requester 0.
